// File: rtl/sub_seq32_pkg.sv
// sub_seq32_pkg
// Shared definitions for the multi-byte subtract sequencer:
//   - state_e        : sequencer state encoding (ST_IDLE, ST_RUN, ST_DONE)
//   - DEFAULT_NBYTES : default number of byte slices
//   - ovf_calc()     : two's complement overflow rule for a subtraction
package sub_seq32_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEFAULT_NBYTES = 4;

    // Signed overflow of a - b: the operands have different signs and the
    // result sign differs from the minuend sign.
    function automatic logic ovf_calc(input logic a_msb, input logic b_msb,
                                      input logic d_msb);
        return (a_msb ^ b_msb) & (d_msb ^ a_msb);
    endfunction

endpackage

// File: rtl/sub_seq32_if.sv
// sub_seq32_if
// Request/result bundle of the multi-byte subtract sequencer.
//   start, a, b, bin              : request side (driven by master)
//   busy, done, diff, borrow,
//   zero, ovf                     : result side (driven by slave)
interface sub_seq32_if #(
    parameter int NBYTES = sub_seq32_pkg::DEFAULT_NBYTES
);
    localparam int W = 8 * NBYTES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         zero;
    logic         ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, borrow, zero, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, borrow, zero, ovf
    );

endinterface

// File: rtl/sub8.sv
// sub8
// 8-bit borrow-chained subtractor: {borrow, diff} = a - b - c.
//   diff   : 8-bit difference byte
//   borrow : 1 when a < b + c (unsigned)
//   a, b   : byte operands
//   c      : borrow-in
module sub8 (
    output logic [7:0] diff,
    output logic       borrow,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       c
);

    logic [8:0] wide_s;

    // Nine-bit subtraction; the wrap into bit 8 is the borrow-out.
    always_comb begin
        wide_s = {1'b0, a} - {1'b0, b} - {8'd0, c};
        diff   = wide_s[7:0];
        borrow = wide_s[8];
    end

endmodule

// File: rtl/sub_seq32.sv
// sub_seq32
// Multi-byte subtract sequencer. Latches a, b, bin on an accepted start and
// streams one byte per clock (LSB first) through a single sub8, rebuilding
// diff and producing final borrow, zero and signed-overflow flags.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : sub_seq32_if slave modport (start/a/b/bin in; busy/done/diff/
//         borrow/zero/ovf out, all registered)
module sub_seq32
    import sub_seq32_pkg::*;
#(
    parameter int NBYTES = DEFAULT_NBYTES
) (
    input  logic        clk,
    input  logic        rst,
    sub_seq32_if.slave  bus
);

    localparam int W     = 8 * NBYTES;
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_e           state_q,  state_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic [W-1:0]     a_q,      a_d;
    logic [W-1:0]     b_q,      b_d;
    logic             chain_q,  chain_d;   // running borrow between bytes
    logic             zacc_q,   zacc_d;    // all bytes so far were zero
    logic [W-1:0]     diff_q,   diff_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             borrow_q, borrow_d;
    logic             zero_q,   zero_d;
    logic             ovf_q,    ovf_d;

    logic [7:0]       a_byte_s;
    logic [7:0]       b_byte_s;
    logic [7:0]       sub_diff_s;
    logic             sub_borrow_s;

    // Byte select: AND-OR mux of the operand registers on idx.
    always_comb begin
        a_byte_s = 8'h00;
        b_byte_s = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            a_byte_s = a_byte_s | (a_q[8*i +: 8] & {8{idx_q == IDX_W'(i)}});
            b_byte_s = b_byte_s | (b_q[8*i +: 8] & {8{idx_q == IDX_W'(i)}});
        end
    end

    sub8 u_sub8 (
        .diff   (sub_diff_s),
        .borrow (sub_borrow_s),
        .a      (a_byte_s),
        .b      (b_byte_s),
        .c      (chain_q)
    );

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        chain_d  = chain_q;
        zacc_d   = zacc_q;
        diff_d   = diff_q;
        busy_d   = busy_q;
        done_d   = done_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;

        case (state_q)
            // DONE accepts a new request exactly like IDLE (back-to-back).
            ST_IDLE, ST_DONE: begin
                done_d = 1'b0;
                if (bus.start) begin
                    state_d = ST_RUN;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    chain_d = bus.bin;
                    zacc_d  = 1'b1;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end

            ST_RUN: begin
                // One-hot byte write enable from idx.
                for (int i = 0; i < NBYTES; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        diff_d[8*i +: 8] = sub_diff_s;
                    end else begin
                        diff_d[8*i +: 8] = diff_q[8*i +: 8];
                    end
                end
                chain_d = sub_borrow_s;
                zacc_d  = zacc_q & (sub_diff_s == 8'h00);

                if (idx_q == LAST_IDX) begin
                    // Flags are registered now so they are valid with done.
                    state_d  = ST_DONE;
                    idx_d    = '0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    borrow_d = sub_borrow_s;
                    zero_d   = zacc_q & (sub_diff_s == 8'h00);
                    ovf_d    = ovf_calc(a_q[W-1], b_q[W-1], sub_diff_s[7]);
                end else begin
                    idx_d    = idx_q + IDX_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            chain_q  <= 1'b0;
            zacc_q   <= 1'b0;
            diff_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            chain_q  <= chain_d;
            zacc_q   <= zacc_d;
            diff_q   <= diff_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
    assign bus.zero   = zero_q;
    assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_sub_seq32.sv
// tb_sub_seq32
// Self-checking bench for sub_seq32 (NBYTES = 4): directed cases plus random
// operands compared against a plain-arithmetic reference model.
module tb_sub_seq32;

    localparam int NB = 4;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    sub_seq32_if #(.NBYTES(NB)) bus ();

    sub_seq32 #(.NBYTES(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: a - b - bin evaluated as plain integers.
    task automatic model(input logic [31:0] ta, input logic [31:0] tb, input logic tbin,
                         output logic [31:0] d, output logic bo, output logic z,
                         output logic ov);
        longint res;
        d   = ta - tb - 32'(tbin);
        bo  = ({32'd0, ta} < ({32'd0, tb} + 64'(tbin)));
        z   = (d == 32'd0);
        res = longint'($signed(ta)) - longint'($signed(tb)) - longint'(tbin);
        ov  = (res > 64'sd2147483647) || (res < -64'sd2147483648);
    endtask

    task automatic chk_result(input string tag, input logic [31:0] ta,
                              input logic [31:0] tb, input logic tbin);
        logic [31:0] d;
        logic bo, z, ov;
        model(ta, tb, tbin, d, bo, z, ov);
        chk({tag, ".diff"},   64'(bus.diff),   64'(d));
        chk({tag, ".borrow"}, 64'(bus.borrow), 64'(bo));
        chk({tag, ".zero"},   64'(bus.zero),   64'(z));
        chk({tag, ".ovf"},    64'(bus.ovf),    64'(ov));
    endtask

    // One operation. poke_at >= 0 re-asserts start with junk operands at that
    // many edges past the start edge (while still running).
    task automatic op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                      input logic tbin, input int poke_at);
        int lat;
        int busy_cnt;
        bit seen;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb;
        bus.bin   = tbin;
        @(posedge clk);            // start edge E0
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.bin   = 1'($urandom_range(1, 0));
        lat = 0;
        busy_cnt = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                if (bus.busy) busy_cnt++;
                bus.start = (lat == poke_at);
                @(negedge clk);
                lat++;
            end
        end
        bus.start = 1'b0;
        chk({tag, ".done_seen"}, 64'(seen), 64'd1);
        chk({tag, ".latency"},   64'(lat),  64'(NB));
        chk({tag, ".busy_cyc"},  64'(busy_cnt), 64'(NB));
        chk({tag, ".busy_done"}, 64'(bus.busy), 64'd0);
        chk_result(tag, ta, tb, tbin);
        @(negedge clk);
        chk({tag, ".done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb, xa, xb;
        int lat;
        int done_cnt;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.a = 32'd0;
        bus.b = 32'd0;
        bus.bin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.busy",   64'(bus.busy),   64'd0);
        chk("rst.done",   64'(bus.done),   64'd0);
        chk("rst.diff",   64'(bus.diff),   64'd0);
        chk("rst.flags",  64'({bus.borrow, bus.zero, bus.ovf}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases.
        op("d_ff",     32'h0000_0100, 32'h0000_0001, 1'b0, -1);
        op("ripple",   32'h0000_0000, 32'h0000_0001, 1'b0, -1);
        op("ovf_neg",  32'h8000_0000, 32'h0000_0001, 1'b0, -1);
        op("ovf_pos",  32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1);
        op("eq_b0",    32'h1234_5678, 32'h1234_5678, 1'b0, -1);
        op("eq_b1",    32'h1234_5678, 32'h1234_5678, 1'b1, -1);
        op("ign_start", 32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 2);

        // Back-to-back: start held high through DONE.
        ra = 32'hCAFE_0001; rb = 32'h0000_0002;
        xa = 32'h0000_0005; xb = 32'h0000_0007;
        @(negedge clk);
        bus.start = 1'b1; bus.a = ra; bus.b = rb; bus.bin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.a = xa; bus.b = xb; bus.bin = 1'b1;
        lat = 0;
        while (!bus.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b.lat1", 64'(lat), 64'(NB));
        chk_result("b2b.op1", ra, rb, 1'b0);
        @(negedge clk);
        lat++;
        bus.start = 1'b0;
        chk("b2b.nogap_busy", 64'(bus.busy), 64'd1);
        chk("b2b.nogap_done", 64'(bus.done), 64'd0);
        while (!bus.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b.lat2", 64'(lat), 64'(2 * NB + 1));
        chk_result("b2b.op2", xa, xb, 1'b1);

        // Reset in the middle of RUN (idx = 2).
        @(negedge clk);
        bus.start = 1'b1; bus.a = 32'h0F0F_0F0F; bus.b = 32'h0101_0101; bus.bin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst.busy", 64'(bus.busy), 64'd0);
        chk("mrst.diff", 64'(bus.diff), 64'd0);
        chk("mrst.flags", 64'({bus.done, bus.borrow, bus.zero, bus.ovf}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        chk("mrst.no_done", 64'(done_cnt), 64'd0);
        op("post_rst", 32'h0F0F_0F0F, 32'h0101_0101, 1'b0, -1);

        // Random operands with occasional corner values.
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(3, 0))
                0:       ra = 32'h0000_0000;
                1:       ra = 32'hFFFF_FFFF;
                default: ra = $urandom;
            endcase
            rb = ($urandom_range(4, 0) == 0) ? ra : $urandom;
            op("rnd", ra, rb, 1'($urandom_range(1, 0)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
